// File: rtl/freq_meter_scheduler.sv
// Round-robin scheduler that time-shares one frequency-meter core across NUM_CH channels.
// It drives the clock-mux select, sequences settle/start/wait, and keeps a per-channel result bank.
module freq_meter_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int FREQ_W      = 34,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 150_000_000
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              run_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    output logic [CH_W-1:0]   ch_sel_o,
    output logic              meas_start_o,
    input  logic              meas_done_i,
    input  logic [FREQ_W-1:0] meas_freq_i,
    output logic              upd_valid_o,
    output logic [CH_W-1:0]   upd_ch_o,
    output logic [FREQ_W-1:0] upd_freq_o,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [FREQ_W-1:0] rd_freq_o,
    output logic [NUM_CH-1:0] ch_timeout_o,
    output logic              busy_o
);

    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_STORE
    } state_e;

    state_e              state_q;
    logic [CH_W-1:0]     ch_sel_q;
    logic [CH_W-1:0]     last_q;
    logic [SET_W-1:0]    settle_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                meas_start_q;
    logic                upd_valid_q;
    logic [CH_W-1:0]     upd_ch_q;
    logic [FREQ_W-1:0]   upd_freq_q;
    logic [FREQ_W-1:0]   rd_freq_q;
    logic [NUM_CH-1:0]   ch_timeout_q;
    logic                busy_q;
    logic [FREQ_W-1:0]   bank_q [NUM_CH];

    logic [CH_W-1:0]     sel_d;
    logic                found_d;
    logic [CH_W-1:0]     idx;

    // First enabled channel after the last one served, wrapping around.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        sel_d   = ch_sel_q;
        found_d = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(last_q) + i) % NUM_CH);
            if (!found_d && ch_en_i[idx]) begin
                sel_d   = idx;
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q      <= ST_IDLE;
            ch_sel_q     <= '0;
            last_q       <= CH_W'(NUM_CH - 1);
            settle_cnt_q <= '0;
            wait_cnt_q   <= '0;
            meas_start_q <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_ch_q     <= '0;
            upd_freq_q   <= '0;
            rd_freq_q    <= '0;
            ch_timeout_q <= '0;
            busy_q       <= 1'b0;
            // NOTE: the result bank is a small register file that must read 0 after reset,
            // so it is cleared here rather than left as an unreset RAM.
            for (int i = 0; i < NUM_CH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            meas_start_q <= 1'b0;
            upd_valid_q  <= 1'b0;
            rd_freq_q    <= bank_q[rd_ch_i];

            case (state_q)
                ST_IDLE: begin
                    if (run_i && (ch_en_i != '0)) begin
                        state_q <= ST_SELECT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (found_d) begin
                        ch_sel_q     <= sel_d;
                        settle_cnt_q <= '0;
                        state_q      <= ST_SETTLE;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                        meas_start_q <= 1'b1;
                        state_q      <= ST_START;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_W'(1);
                    end
                end
                ST_START: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done pulse on the final timeout cycle still counts as a result.
                    if (meas_done_i) begin
                        upd_valid_q <= 1'b1;
                        upd_ch_q    <= ch_sel_q;
                        upd_freq_q  <= meas_freq_i;
                        state_q     <= ST_STORE;
                    end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
                        ch_timeout_q[ch_sel_q] <= 1'b1;
                        last_q                 <= ch_sel_q;
                        state_q                <= run_i ? ST_SELECT : ST_IDLE;
                        busy_q                 <= run_i;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_STORE: begin
                    bank_q[ch_sel_q]       <= upd_freq_q;
                    ch_timeout_q[ch_sel_q] <= 1'b0;
                    last_q                 <= ch_sel_q;
                    state_q                <= run_i ? ST_SELECT : ST_IDLE;
                    busy_q                 <= run_i;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ch_sel_o     = ch_sel_q;
    assign meas_start_o = meas_start_q;
    assign upd_valid_o  = upd_valid_q;
    assign upd_ch_o     = upd_ch_q;
    assign upd_freq_o   = upd_freq_q;
    assign rd_freq_o    = rd_freq_q;
    assign ch_timeout_o = ch_timeout_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_freq_meter_scheduler.sv
// Directed bench for freq_meter_scheduler: reset, round-robin, timeout, done/timeout race,
// run dropped mid-measurement and reset during WAIT, with an inline meter model.
module tb_freq_meter_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int FREQ_W = 34;

    logic              sys_clk;
    logic              sys_rst;
    logic              run;
    logic [NUM_CH-1:0] ch_en;
    logic [CH_W-1:0]   ch_sel;
    logic              meas_start;
    logic              meas_done;
    logic [FREQ_W-1:0] meas_freq;
    logic              upd_valid;
    logic [CH_W-1:0]   upd_ch;
    logic [FREQ_W-1:0] upd_freq;
    logic [CH_W-1:0]   rd_ch;
    logic [FREQ_W-1:0] rd_freq;
    logic [NUM_CH-1:0] ch_timeout;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    freq_meter_scheduler #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .FREQ_W     (FREQ_W),
        .SETTLE_CYC (4),
        .TIMEOUT_CYC(100)
    ) dut (
        .sys_clk_i   (sys_clk),
        .sys_rst_i   (sys_rst),
        .run_i       (run),
        .ch_en_i     (ch_en),
        .ch_sel_o    (ch_sel),
        .meas_start_o(meas_start),
        .meas_done_i (meas_done),
        .meas_freq_i (meas_freq),
        .upd_valid_o (upd_valid),
        .upd_ch_o    (upd_ch),
        .upd_freq_o  (upd_freq),
        .rd_ch_i     (rd_ch),
        .rd_freq_o   (rd_freq),
        .ch_timeout_o(ch_timeout),
        .busy_o      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advances until meas_start is seen, returning the number of cycles waited.
    task automatic wait_start(input string tag, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (meas_start !== 1'b1 && cyc < budget);
        check({tag, "_start_seen"}, 64'(meas_start), 64'd1);
    endtask

    // Meter model: called on the START cycle, answers dly cycles after the start pulse.
    task automatic measure(input string tag, input logic [CH_W-1:0] ch,
                           input logic [FREQ_W-1:0] f, input int dly);
        repeat (dly - 1) tick();
        meas_done = 1'b1;
        meas_freq = f;
        tick();
        meas_done = 1'b0;
        meas_freq = '0;
        check({tag, "_upd_valid"}, 64'(upd_valid), 64'd1);
        check({tag, "_upd_ch"},    64'(upd_ch),    64'(ch));
        check({tag, "_upd_freq"},  64'(upd_freq),  64'(f));
    endtask

    initial begin
        int   cyc;
        logic saw_start;
        logic saw_busy;
        logic saw_upd;

        sys_rst   = 1'b1;
        run       = 1'b0;
        ch_en     = '0;
        meas_done = 1'b0;
        meas_freq = '0;
        rd_ch     = '0;

        // 1. Reset, then run with an empty mask.
        repeat (3) tick();
        sys_rst = 1'b0;
        run     = 1'b1;
        check("rst_ch_sel",     64'(ch_sel),     64'd0);
        check("rst_meas_start", 64'(meas_start), 64'd0);
        check("rst_upd_valid",  64'(upd_valid),  64'd0);
        check("rst_upd_ch",     64'(upd_ch),     64'd0);
        check("rst_upd_freq",   64'(upd_freq),   64'd0);
        check("rst_rd_freq",    64'(rd_freq),    64'd0);
        check("rst_ch_timeout", 64'(ch_timeout), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        saw_start = 1'b0;
        saw_busy  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            saw_start |= meas_start;
            saw_busy  |= busy;
        end
        check("empty_no_start", 64'(saw_start), 64'd0);
        check("empty_no_busy",  64'(saw_busy),  64'd0);
        check("empty_ch_sel",   64'(ch_sel),    64'd0);

        // 2. Round-robin over 4'b1011: channels 0,1,3,0.
        ch_en = 4'b1011;
        wait_start("rr0", 30, cyc);
        check("rr_first_latency", 64'(cyc), 64'd6);
        check("rr0_ch_sel", 64'(ch_sel), 64'd0);
        check("rr0_busy",   64'(busy),   64'd1);
        measure("rr0", 2'd0, 34'd1000, 20);
        wait_start("rr1", 30, cyc);
        check("rr1_ch_sel", 64'(ch_sel), 64'd1);
        measure("rr1", 2'd1, 34'd1001, 20);
        wait_start("rr2", 30, cyc);
        check("rr2_ch_sel", 64'(ch_sel), 64'd3);
        measure("rr2", 2'd3, 34'd1003, 20);
        wait_start("rr3", 30, cyc);
        check("rr3_ch_sel", 64'(ch_sel), 64'd0);
        run = 1'b0;
        measure("rr3", 2'd0, 34'd1000, 20);
        tick();
        check("rr_idle_busy", 64'(busy), 64'd0);
        rd_ch = 2'd3;
        tick();
        check("rr_rd3", 64'(rd_freq), 64'd1003);
        rd_ch = 2'd1;
        tick();
        check("rr_rd1", 64'(rd_freq), 64'd1001);
        rd_ch = 2'd2;
        tick();
        check("rr_rd2", 64'(rd_freq), 64'd0);

        // 3. Timeout on channel 2, then a successful retry.
        ch_en = 4'b0100;
        run   = 1'b1;
        wait_start("to", 30, cyc);
        check("to_latency", 64'(cyc),    64'd6);
        check("to_ch_sel",  64'(ch_sel), 64'd2);
        saw_upd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            saw_upd |= upd_valid;
        end
        check("to_flag_before", 64'(ch_timeout), 64'd0);
        tick();
        saw_upd |= upd_valid;
        check("to_flag_set", 64'(ch_timeout), 64'b0100);
        check("to_no_upd",   64'(saw_upd),    64'd0);
        check("to_busy",     64'(busy),       64'd1);
        rd_ch = 2'd2;
        tick();
        check("to_bank_unchanged", 64'(rd_freq), 64'd0);
        wait_start("retry", 30, cyc);
        check("retry_ch_sel",   64'(ch_sel),     64'd2);
        check("retry_flag_hold", 64'(ch_timeout), 64'b0100);
        run = 1'b0;
        measure("retry", 2'd2, 34'd55, 20);
        tick();
        check("retry_flag_clr", 64'(ch_timeout), 64'd0);
        check("retry_busy",     64'(busy),       64'd0);
        tick();
        check("retry_bank", 64'(rd_freq), 64'd55);

        // 4. Done arrives in the 100th WAIT cycle: done wins.
        run = 1'b1;
        wait_start("race", 30, cyc);
        check("race_ch_sel", 64'(ch_sel), 64'd2);
        run = 1'b0;
        measure("race", 2'd2, 34'd77, 101);
        check("race_flag", 64'(ch_timeout), 64'd0);
        tick();
        tick();
        check("race_bank", 64'(rd_freq), 64'd77);
        check("race_flag_after", 64'(ch_timeout), 64'd0);

        // 5. run and the active channel's enable dropped during WAIT.
        ch_en = 4'b0011;
        run   = 1'b1;
        wait_start("drop", 30, cyc);
        check("drop_ch_sel", 64'(ch_sel), 64'd0);
        tick();
        run   = 1'b0;
        ch_en = 4'b0010;
        measure("drop", 2'd0, 34'h2_0000_0001, 9);
        tick();
        check("drop_idle_busy",   64'(busy),   64'd0);
        check("drop_ch_sel_held", 64'(ch_sel), 64'd0);
        rd_ch = 2'd0;
        repeat (5) tick();
        check("drop_still_idle", 64'(busy),    64'd0);
        check("drop_bank",       64'(rd_freq), 64'h2_0000_0001);

        // 6. Reset pulse during WAIT with a late done.
        run = 1'b1;
        wait_start("rstw", 30, cyc);
        check("rstw_ch_sel", 64'(ch_sel), 64'd1);
        repeat (3) tick();
        sys_rst = 1'b1;
        run     = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();
        meas_done = 1'b1;
        meas_freq = 34'd99;
        tick();
        meas_done = 1'b0;
        meas_freq = '0;
        check("rstw_no_upd",  64'(upd_valid),  64'd0);
        check("rstw_busy",    64'(busy),       64'd0);
        check("rstw_ch_sel",  64'(ch_sel),     64'd0);
        check("rstw_flags",   64'(ch_timeout), 64'd0);
        check("rstw_upd_freq", 64'(upd_freq),  64'd0);
        rd_ch = 2'd3;
        tick();
        check("rstw_bank3", 64'(rd_freq), 64'd0);
        rd_ch = 2'd0;
        tick();
        check("rstw_bank0", 64'(rd_freq), 64'd0);
        tick();
        check("rstw_no_upd_late", 64'(upd_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
